shram_arbiter: RTL and testbench
================================

Name: shram_arbiter

Overview:
- Arbitrates the single-port, byte-laned 32-bit shared RAM between two requesters:
  - the CPU word port (valid/ready);
  - the USB device byte port (wen/ren strobes, no backpressure).
- USB always wins a cycle; CPU accesses are slotted into USB-idle cycles.
- Handles byte-lane steering, one-cycle RAM read latency routing, and CPU ready generation.
- Flags CPU starvation.
- Sits between CPU address decode, USB core and the four 8-bit RAM banks in the SoC top.

Parameters:
AW, 10, byte address width of the RAM (word address width = AW-2).
CPU_WAIT_MAX, 64, CPU wait cycles before the starvation flag sets; valid range 1..255.

Ports:
i_clk  in  1  system clock (48 MHz).
i_rst_n  in  1  asynchronous active-low reset.
i_cpu_valid  in  1  CPU request, already qualified by the RAM region decode.
i_cpu_addr  in  AW  CPU byte address; bits [1:0] ignored.
i_cpu_wdata  in  32  CPU write data.
i_cpu_wstrb  in  4  CPU byte write strobes; 0 = read.
o_cpu_rdata  out  32  CPU read data, valid while o_cpu_ready=1.
o_cpu_ready  out  1  one-cycle completion pulse.
i_usb_wen  in  1  USB byte write strobe.
i_usb_ren  in  1  USB byte read strobe.
i_usb_addr  in  AW  USB byte address.
i_usb_wdata  in  8  USB write byte.
o_usb_rdata  out  8  USB read byte, lane-selected.
o_usb_rvalid  out  1  one-cycle pulse the cycle after an accepted USB read.
o_ram_ce  out  1  RAM chip enable.
o_ram_addr  out  AW-2  RAM word address.
o_ram_wdata  out  32  RAM write data.
o_ram_we  out  4  RAM per-lane write enables.
i_ram_rdata  in  32  RAM read data, registered, valid one cycle after ce.
i_starve_clr  in  1  clears the sticky starvation flag.
o_cpu_starve  out  1  sticky starvation flag.

Behaviour:
- Reset is asynchronous, active-low, and fixed:
  - all registers clear; o_cpu_ready=0, o_usb_rvalid=0, o_cpu_starve=0, wait counter=0, CPU FSM=IDLE;
  - a CPU access interrupted by reset never receives ready;
  - while i_rst_n=0, RAM outputs are driven only by USB strobes and are ignored by the system.
- USB slot: cycle with i_usb_wen|i_usb_ren. RAM outputs are combinational from the USB inputs:
  - ce=1; addr=i_usb_addr[AW-1:2];
  - wdata={4{i_usb_wdata}};
  - we=i_usb_wen<<i_usb_addr[1:0].
- USB wen and ren together: the write is performed, the read is dropped, no rvalid.
- USB read latency 1:
  - lane register captures i_usb_addr[1:0] on an accepted read;
  - next cycle o_usb_rvalid=1 and o_usb_rdata=i_ram_rdata byte[lane];
  - o_usb_rdata holds its last value otherwise.
- CPU FSM IDLE:
  - if i_cpu_valid & no USB slot: issue; RAM ce=1, addr=i_cpu_addr[AW-1:2], wdata=i_cpu_wdata, we=i_cpu_wstrb; go to RESP;
  - if i_cpu_valid & USB slot: stay in IDLE, wait counter +1;
  - if !i_cpu_valid: wait counter=0.
- CPU FSM RESP:
  - o_cpu_ready=1 and o_cpu_rdata=i_ram_rdata (write data is don't-care);
  - no CPU issue in this cycle, even though i_cpu_valid is still high;
  - return to IDLE; wait counter=0.
- Latency, no contention: issue at T, ready at T+1; next request issue no earlier than T+2.
- An issued CPU access is never aborted by a later USB strobe. A USB strobe during RESP uses the RAM normally; CPU data comes from the T access, and the RAM output is not updated until the next clock edge.
- Starvation:
  - wait counter saturates at 255;
  - o_cpu_starve sets when the counter reaches CPU_WAIT_MAX and stays set until i_starve_clr;
  - simultaneous set and clear: set wins.
- i_cpu_valid dropped while waiting in IDLE: abandon the request, no ready, counter=0.

Optional Feature:
- Macro SHRAM_CONFLICT_CNT_EN.
- Defined:
  - adds output o_conflict_cnt, out, 16;
  - 16-bit counter increments each cycle the CPU waits in IDLE because of a USB slot;
  - saturates at 0xFFFF; reset 0; cleared by i_starve_clr (increment wins if simultaneous, result 1).
- Undefined: no port, no counter logic; all other behaviour identical.

Test Plan:
- Idle USB, CPU write 0xA5A5_1234 wstrb=0xF addr 0x010, then read addr 0x010 -> writes: ce/we=0xF at T, ready at T+1; read returns 0xA5A5_1234 with ready exactly one cycle after issue.
- USB wen addr 0x013 data 0x7E, then ren addr 0x013 -> write drives we=0x8, wdata=0x7E7E7E7E; read gives rvalid next cycle with o_usb_rdata=0x7E.
- CPU valid read while USB strobes for 5 consecutive cycles -> no ce for CPU during those 5 cycles; issue on the 6th; ready on the 7th; o_cpu_starve stays 0 with CPU_WAIT_MAX=64.
- USB strobes every cycle for 70 cycles while CPU valid, CPU_WAIT_MAX=64 -> o_cpu_starve sets at the 64th wait cycle and remains set until i_starve_clr pulses; conflict count reads 70 when the feature is enabled.
- USB ren issued during CPU RESP cycle -> CPU receives the RAM word from its own access; USB rvalid next cycle with the correct byte; no corruption of either.
- Reset asserted in the cycle after CPU issue -> o_cpu_ready never pulses; all flags 0 after release.

Source files
------------

// File: rtl/shram_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : shram_arbiter
// Description : Shares one single-port, byte-laned 32-bit RAM between the CPU
//               word port (valid/ready) and the USB device byte port
//               (wen/ren strobes, no backpressure). USB always owns the RAM
//               in any cycle it strobes; CPU accesses are issued only in
//               USB-idle cycles. Steers byte lanes, routes the one-cycle RAM
//               read latency back to the right requester, generates CPU
//               ready, and raises a sticky starvation flag.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters  : AW            byte address width of the RAM
//               CPU_WAIT_MAX  CPU wait cycles before starvation (1..255)
// Ports       : i_clk, i_rst_n            clock, async active-low reset
//               i_cpu_*  / o_cpu_*        CPU word request / response
//               i_usb_*  / o_usb_*        USB byte strobes / read response
//               o_ram_*  / i_ram_rdata    RAM bank interface (1-cycle read)
//               i_starve_clr, o_cpu_starve  sticky starvation flag
//               o_conflict_cnt            CPU-blocked cycle count (optional)
// Options     : define SHRAM_CONFLICT_CNT_EN to add o_conflict_cnt and its
//               saturating 16-bit counter.
// ============================================================================
module shram_arbiter #(
    parameter int AW           = 10,
    parameter int CPU_WAIT_MAX = 64
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_cpu_valid,
    input  logic [AW-1:0] i_cpu_addr,
    input  logic [31:0]   i_cpu_wdata,
    input  logic [3:0]    i_cpu_wstrb,
    output logic [31:0]   o_cpu_rdata,
    output logic          o_cpu_ready,
    input  logic          i_usb_wen,
    input  logic          i_usb_ren,
    input  logic [AW-1:0] i_usb_addr,
    input  logic [7:0]    i_usb_wdata,
    output logic [7:0]    o_usb_rdata,
    output logic          o_usb_rvalid,
    output logic          o_ram_ce,
    output logic [AW-3:0] o_ram_addr,
    output logic [31:0]   o_ram_wdata,
    output logic [3:0]    o_ram_we,
    input  logic [31:0]   i_ram_rdata,
    input  logic          i_starve_clr,
    output logic          o_cpu_starve
`ifdef SHRAM_CONFLICT_CNT_EN
    ,
    output logic [15:0]   o_conflict_cnt
`endif
);

    // Counter value that, when incremented by one more wait, reaches the limit.
    localparam logic [7:0] c_wait_last = 8'(CPU_WAIT_MAX - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RESP = 1'b1
    } cpu_state_e;

    cpu_state_e  state_q, state_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic        starve_q, starve_d;
    logic [1:0]  usb_lane_q, usb_lane_d;
    logic        usb_rvalid_q, usb_rvalid_d;
    logic [7:0]  usb_hold_q, usb_hold_d;

    logic        w_usb_slot;
    logic        w_usb_rd_acc;
    logic [3:0]  w_usb_we;
    logic [7:0]  w_usb_lane_byte;
    logic        w_cpu_issue;
    logic        w_cpu_wait;
    logic        w_starve_set;

    // CPU byte-offset bits have no meaning for word accesses.
    logic        w_unused_cpu_lsb;
    assign w_unused_cpu_lsb = ^i_cpu_addr[1:0];

    assign w_usb_slot      = i_usb_wen | i_usb_ren;
    // A simultaneous read strobe is dropped in favour of the write.
    assign w_usb_rd_acc    = i_usb_ren & ~i_usb_wen;
    assign w_usb_we        = {3'b000, i_usb_wen} << i_usb_addr[1:0];
    assign w_usb_lane_byte = i_ram_rdata[{usb_lane_q, 3'b000} +: 8];

    // ------------------------------------------------------------------
    // CPU FSM: next state and issue/wait decisions
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        w_cpu_issue = 1'b0;
        w_cpu_wait  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_cpu_valid) begin
                    if (w_usb_slot) begin
                        w_cpu_wait = 1'b1;
                    end else begin
                        w_cpu_issue = 1'b1;
                        state_d     = S_RESP;
                    end
                end
            end
            // The response cycle never issues, so valid held high here is
            // not mistaken for a second request.
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // RAM port steering. USB drives the RAM whenever it strobes; the CPU
    // only gets it in idle cycles and never while reset is held.
    // ------------------------------------------------------------------
    always_comb begin
        o_ram_ce    = 1'b0;
        o_ram_addr  = '0;
        o_ram_wdata = '0;
        o_ram_we    = 4'b0000;
        if (w_usb_slot) begin
            o_ram_ce    = 1'b1;
            o_ram_addr  = i_usb_addr[AW-1:2];
            o_ram_wdata = {4{i_usb_wdata}};
            o_ram_we    = w_usb_we;
        end else if (w_cpu_issue && i_rst_n) begin
            o_ram_ce    = 1'b1;
            o_ram_addr  = i_cpu_addr[AW-1:2];
            o_ram_wdata = i_cpu_wdata;
            o_ram_we    = i_cpu_wstrb;
        end
    end

    // ------------------------------------------------------------------
    // Wait counter, starvation flag and USB read-return tracking
    // ------------------------------------------------------------------
    always_comb begin
        wait_cnt_d = 8'd0;
        if (w_cpu_wait) begin
            wait_cnt_d = (wait_cnt_q == 8'hFF) ? 8'hFF : wait_cnt_q + 8'd1;
        end
    end

    // Set fires only on the wait that takes the count up to the limit.
    assign w_starve_set = w_cpu_wait && (wait_cnt_q == c_wait_last);
    assign starve_d     = w_starve_set | (starve_q & ~i_starve_clr);

    assign usb_lane_d   = w_usb_rd_acc ? i_usb_addr[1:0] : usb_lane_q;
    assign usb_rvalid_d = w_usb_rd_acc;
    assign usb_hold_d   = usb_rvalid_q ? w_usb_lane_byte : usb_hold_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= S_IDLE;
            wait_cnt_q   <= 8'd0;
            starve_q     <= 1'b0;
            usb_lane_q   <= 2'd0;
            usb_rvalid_q <= 1'b0;
            usb_hold_q   <= 8'd0;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            starve_q     <= starve_d;
            usb_lane_q   <= usb_lane_d;
            usb_rvalid_q <= usb_rvalid_d;
            usb_hold_q   <= usb_hold_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs. The RAM output register still holds the CPU word during the
    // response cycle, even if USB is accessing the RAM in that cycle.
    // ------------------------------------------------------------------
    assign o_cpu_ready  = (state_q == S_RESP);
    assign o_cpu_rdata  = (state_q == S_RESP) ? i_ram_rdata : 32'd0;
    assign o_usb_rvalid = usb_rvalid_q;
    assign o_usb_rdata  = usb_rvalid_q ? w_usb_lane_byte : usb_hold_q;
    assign o_cpu_starve = starve_q;

`ifdef SHRAM_CONFLICT_CNT_EN
    logic [15:0] conflict_cnt_q, conflict_cnt_d;

    // An increment coinciding with a clear restarts the count at one.
    always_comb begin
        conflict_cnt_d = conflict_cnt_q;
        if (w_cpu_wait) begin
            if (i_starve_clr) begin
                conflict_cnt_d = 16'd1;
            end else if (conflict_cnt_q != 16'hFFFF) begin
                conflict_cnt_d = conflict_cnt_q + 16'd1;
            end
        end else if (i_starve_clr) begin
            conflict_cnt_d = 16'd0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            conflict_cnt_q <= 16'd0;
        end else begin
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    assign o_conflict_cnt = conflict_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_shram_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_shram_arbiter
// Description : Self-checking bench for shram_arbiter. Directed scenarios
//               followed by randomized traffic, each cycle compared against
//               a transaction-level reference of the arbitration rules and a
//               byte-array image of the RAM contents.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shram_arbiter;

    localparam int AW   = 10;
    localparam int WMAX = 64;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_valid;
    logic [9:0]  cpu_addr;
    logic [31:0] cpu_wdata;
    logic [3:0]  cpu_wstrb;
    logic [31:0] cpu_rdata;
    logic        cpu_ready;
    logic        usb_wen;
    logic        usb_ren;
    logic [9:0]  usb_addr;
    logic [7:0]  usb_wdata;
    logic [7:0]  usb_rdata;
    logic        usb_rvalid;
    logic        ram_ce;
    logic [7:0]  ram_addr;
    logic [31:0] ram_wdata;
    logic [3:0]  ram_we;
    logic [31:0] ram_q;
    logic        starve_clr;
    logic        cpu_starve;
`ifdef SHRAM_CONFLICT_CNT_EN
    logic [15:0] conflict_cnt;
`endif

    always #5 clk = ~clk;

    shram_arbiter #(.AW(AW), .CPU_WAIT_MAX(WMAX)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_cpu_valid  (cpu_valid),
        .i_cpu_addr   (cpu_addr),
        .i_cpu_wdata  (cpu_wdata),
        .i_cpu_wstrb  (cpu_wstrb),
        .o_cpu_rdata  (cpu_rdata),
        .o_cpu_ready  (cpu_ready),
        .i_usb_wen    (usb_wen),
        .i_usb_ren    (usb_ren),
        .i_usb_addr   (usb_addr),
        .i_usb_wdata  (usb_wdata),
        .o_usb_rdata  (usb_rdata),
        .o_usb_rvalid (usb_rvalid),
        .o_ram_ce     (ram_ce),
        .o_ram_addr   (ram_addr),
        .o_ram_wdata  (ram_wdata),
        .o_ram_we     (ram_we),
        .i_ram_rdata  (ram_q),
        .i_starve_clr (starve_clr),
        .o_cpu_starve (cpu_starve)
`ifdef SHRAM_CONFLICT_CNT_EN
        ,
        .o_conflict_cnt (conflict_cnt)
`endif
    );

    // Behavioural RAM: read-before-write, output register holds between accesses.
    logic [31:0] ram_mem [256];
    always @(posedge clk) begin
        if (ram_ce) begin
            ram_q <= ram_mem[ram_addr];
            for (int i = 0; i < 4; i++) begin
                if (ram_we[i]) ram_mem[ram_addr][8*i +: 8] <= ram_wdata[8*i +: 8];
            end
        end
    end

    // Reference model state
    logic [7:0]  ref_b [1024];
    bit          m_pend;
    logic [31:0] m_pend_data;
    bit          m_rd;
    logic [7:0]  m_rd_byte;
    logic [7:0]  m_hold;
    int          m_waits;
    bit          m_starve;
    int          m_conf;

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [31:0] ref_word(input int a);
        int b;
        b = a & ~3;
        return {ref_b[b+3], ref_b[b+2], ref_b[b+1], ref_b[b]};
    endfunction

    task automatic model_reset();
        m_pend      = 0;
        m_pend_data = '0;
        m_rd        = 0;
        m_rd_byte   = '0;
        m_hold      = '0;
        m_waits     = 0;
        m_starve    = 0;
        m_conf      = 0;
    endtask

    // One clock cycle: inputs already applied; check, clock, advance model.
    task automatic step();
        bit          slot, issue, waiting, rd_acc, set_st, e_ce;
        logic [3:0]  e_we;
        logic [7:0]  e_addr;
        logic [31:0] e_wd;
        logic [7:0]  nxt_rd_byte;
        logic [31:0] nxt_pend_data;
        #1;
        if (!rst_n) model_reset();
        slot    = usb_wen || usb_ren;
        issue   = rst_n && cpu_valid && !slot && !m_pend;
        waiting = rst_n && cpu_valid && slot && !m_pend;
        rd_acc  = usb_ren && !usb_wen;
        e_ce = 0; e_we = '0; e_addr = '0; e_wd = '0;
        if (slot) begin
            e_ce   = 1;
            e_addr = usb_addr[9:2];
            e_wd   = {4{usb_wdata}};
            e_we   = usb_wen ? (4'b0001 << usb_addr[1:0]) : 4'b0000;
        end else if (issue) begin
            e_ce   = 1;
            e_addr = cpu_addr[9:2];
            e_wd   = cpu_wdata;
            e_we   = cpu_wstrb;
        end
        if (rst_n) begin
            chk("ram_ce", ram_ce, e_ce);
            chk("ram_we", ram_we, e_we);
            if (e_ce) begin
                chk("ram_addr", ram_addr, e_addr);
                chk("ram_wdata", ram_wdata, e_wd);
            end
        end
        chk("cpu_ready", cpu_ready, m_pend);
        if (m_pend) chk("cpu_rdata", cpu_rdata, m_pend_data);
        chk("usb_rvalid", usb_rvalid, m_rd);
        chk("usb_rdata", usb_rdata, m_rd ? m_rd_byte : m_hold);
        chk("cpu_starve", cpu_starve, m_starve);
`ifdef SHRAM_CONFLICT_CNT_EN
        chk("conflict_cnt", conflict_cnt, m_conf);
`endif
        nxt_pend_data = ref_word(cpu_addr);
        nxt_rd_byte   = ref_b[usb_addr];
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            if (m_rd) m_hold = m_rd_byte;
            m_pend = issue;
            if (issue) m_pend_data = nxt_pend_data;
            m_rd = rd_acc;
            if (rd_acc) m_rd_byte = nxt_rd_byte;
            if (e_ce) begin
                for (int i = 0; i < 4; i++) begin
                    if (e_we[i]) ref_b[int'(e_addr) * 4 + i] = e_wd[8*i +: 8];
                end
            end
            set_st = 0;
            if (waiting) begin
                if (m_waits < WMAX && m_waits + 1 >= WMAX) set_st = 1;
                m_waits = (m_waits < 255) ? m_waits + 1 : 255;
                m_conf  = starve_clr ? 1 : ((m_conf < 65535) ? m_conf + 1 : 65535);
            end else begin
                m_waits = 0;
                if (starve_clr) m_conf = 0;
            end
            m_starve = set_st || (m_starve && !starve_clr);
        end
        #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++)  ram_mem[i] = '0;
        for (int i = 0; i < 1024; i++) ref_b[i]   = '0;
        ram_q = '0;
        model_reset();
        rst_n = 0; cpu_valid = 0; cpu_addr = '0; cpu_wdata = '0; cpu_wstrb = '0;
        usb_wen = 0; usb_ren = 0; usb_addr = '0; usb_wdata = '0; starve_clr = 0;

        // Reset state
        step(); step();
        chk("rst_ready", cpu_ready, 0);
        chk("rst_rvalid", usb_rvalid, 0);
        chk("rst_starve", cpu_starve, 0);
        rst_n = 1;
        step();

        // CPU write then read, idle USB
        cpu_valid = 1; cpu_addr = 10'h010; cpu_wdata = 32'hA5A5_1234; cpu_wstrb = 4'hF;
        step();                       // issue
        step();                       // ready
        cpu_wstrb = 4'h0;
        step();                       // issue read
        step();                       // ready with data
        cpu_valid = 0;
        step();
        chk("wr_rd_word", ref_word(10'h010), 32'hA5A5_1234);

        // USB byte write then read of lane 3
        usb_wen = 1; usb_addr = 10'h013; usb_wdata = 8'h7E;
        step();
        usb_wen = 0; usb_ren = 1;
        step();
        usb_ren = 0;
        #1;
        chk("usb_rd_byte", usb_rdata, 8'h7E);
        chk("usb_rd_valid", usb_rvalid, 1);
        step();

        // Five cycles of USB contention, CPU issues on the sixth
        cpu_valid = 1; cpu_addr = 10'h010; cpu_wstrb = 4'h0;
        for (int i = 0; i < 5; i++) begin
            usb_ren = 1; usb_addr = 10'(i * 4 + 64);
            step();
        end
        usb_ren = 0;
        step();                       // issue
        step();                       // ready
        cpu_valid = 0;
        chk("short_wait_starve", cpu_starve, 0);
        step();

        // Starvation: 70 USB cycles while CPU waits
        cpu_valid = 1; cpu_addr = 10'h020; cpu_wstrb = 4'h0;
        for (int i = 1; i <= 70; i++) begin
            usb_ren = 1; usb_addr = 10'(i);
            step();
            if (i == WMAX - 1) chk("starve_before_limit", cpu_starve, 0);
            if (i == WMAX)     chk("starve_at_limit", cpu_starve, 1);
        end
`ifdef SHRAM_CONFLICT_CNT_EN
        chk("conflict_70", conflict_cnt, 70);
`endif
        usb_ren = 0;
        step(); step();
        cpu_valid = 0;
        step();
        chk("starve_sticky", cpu_starve, 1);
        starve_clr = 1;
        step();
        starve_clr = 0;
        step();
        chk("starve_cleared", cpu_starve, 0);

        // USB read during CPU response cycle
        cpu_valid = 1; cpu_addr = 10'h010; cpu_wstrb = 4'h0;
        step();                       // CPU issue
        usb_ren = 1; usb_addr = 10'h011;
        step();                       // CPU ready, USB read accepted
        usb_ren = 0; cpu_valid = 0;
        #1;
        chk("resp_usb_byte", usb_rdata, 8'h12);
        step();

        // Reset right after a CPU issue
        cpu_valid = 1; cpu_addr = 10'h020; cpu_wstrb = 4'h0;
        step();                       // issue
        rst_n = 0; cpu_valid = 0;
        #1;
        chk("rst_kills_ready", cpu_ready, 0);
        step(); step();
        rst_n = 1;
        step();
        chk("post_rst_ready", cpu_ready, 0);
        chk("post_rst_starve", cpu_starve, 0);
        step();

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            int  r;
            bit  was_resp;
            r = $urandom_range(0, 9);
            usb_wen   = (r == 0 || r == 1 || r == 3);
            usb_ren   = (r == 2 || r == 3 || r == 4);
            usb_addr  = 10'($urandom_range(0, 63));
            usb_wdata = 8'($urandom);
            if (!cpu_valid) begin
                if ($urandom_range(0, 1) == 1) begin
                    cpu_valid = 1;
                    cpu_addr  = 10'($urandom_range(0, 63));
                    cpu_wdata = $urandom;
                    cpu_wstrb = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 15)) : 4'h0;
                end
            end else if (!m_pend && $urandom_range(0, 19) == 0) begin
                cpu_valid = 0;        // abandon while waiting
            end
            starve_clr = ($urandom_range(0, 49) == 0);
            was_resp = m_pend;
            step();
            if (was_resp) cpu_valid = 0;
        end
        usb_wen = 0; usb_ren = 0; cpu_valid = 0; starve_clr = 0;
        step(); step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
